// File: rtl/ni_packetizer_pkg.sv
// Shared flit format and FSM encodings for the network-interface packetizer
// and its mirror depacketizer.
package ni_packetizer_pkg;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam int ID_LSB  = 29;
    localparam int LEN_LSB = 17;
    localparam int DST_LSB = 13;
    localparam int SRC_LSB = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } ni_state_e;

endpackage

// File: rtl/ni_packetizer.sv
// Transmit half of the network interface: turns a core request plus payload
// stream into header/body/tail flits for the router's Local input port.
module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 12,
    parameter int PAY_WIDTH  = 29
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_dst,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [PAY_WIDTH-1:0]  pay_data,
    input  logic                  pay_valid,
    output logic                  pay_ready,
    output logic [DATA_WIDTH-1:0] flit_data,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  busy,
    output logic                  len_err
);

    ni_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  len_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dst_q       <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            len_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            len_err     <= len_err_d;
        end
    end

    // The router writes whenever valid is high, so valid is always gated by ready.
    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        len_err_d   = 1'b0;
        req_ready   = 1'b0;
        busy        = 1'b0;
        pay_ready   = 1'b0;
        flit_valid  = 1'b0;
        flit_data   = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_len >= LEN_WIDTH'(2)) begin
                        dst_d   = req_dst;
                        len_d   = req_len;
                        state_d = ST_HDR;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                busy       = 1'b1;
                flit_valid = flit_ready;
                flit_data  = {FLIT_HEADER, len_q, dst_q, cur_addr, {SRC_LSB{1'b0}}};
                if (flit_ready) begin
                    remaining_d = len_q - LEN_WIDTH'(1);
                    state_d     = ST_PAY;
                end
            end
            ST_PAY: begin
                busy       = 1'b1;
                pay_ready  = flit_ready;
                flit_valid = pay_valid && flit_ready;
                flit_data  = {(remaining_q == LEN_WIDTH'(1)) ? FLIT_TAIL : FLIT_BODY, pay_data};
                // Exit on remaining==1 so the counter never wraps, even at max length.
                if (pay_valid && flit_ready) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
